// File: rtl/usb_dev_line_ctrl.sv
// Device-side USB line-state controller and Dp/Dm transmit arbiter.
// Optional low-speed decode (swapped J/K) is enabled by defining USB_DEV_LINE_CTRL_LS_EN.
module usb_dev_line_ctrl #(
    parameter int CON_TICKS    = 30,
    parameter int RST_TICKS    = 30,
    parameter int SUSP_TICKS   = 36000,
    parameter int RESUME_TICKS = 12000,
    parameter int CNT_W        = 16
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       bit_tick,
    input  logic       vbus,
    input  logic       line_dp,
    input  logic       line_dm,
    input  logic       rwk_req,
    input  logic       hs_req,
    input  logic       data_req,
    input  logic       tx_done,
    output logic       pullup_en,
    output logic       tx_oe,
    output logic       drive_k,
    output logic       hs_gnt,
    output logic       data_gnt,
    output logic       bus_reset,
    output logic       bus_reset_p,
    output logic       suspend,
    output logic [2:0] state
);

    localparam logic [2:0] ST_DETACH      = 3'd0;
    localparam logic [2:0] ST_ATTACH_WAIT = 3'd1;
    localparam logic [2:0] ST_IDLE        = 3'd2;
    localparam logic [2:0] ST_BUS_RST     = 3'd3;
    localparam logic [2:0] ST_SUSPEND     = 3'd4;
    localparam logic [2:0] ST_RESUME_DRV  = 3'd5;
    localparam logic [2:0] ST_RESUME_WAIT = 3'd6;

    localparam logic [CNT_W-1:0] CNT_ZERO    = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CON_LAST    = CNT_W'(CON_TICKS - 1);
    localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_TICKS - 1);
    localparam logic [CNT_W-1:0] SUSP_LAST   = CNT_W'(SUSP_TICKS - 1);
    localparam logic [CNT_W-1:0] RESUME_LAST = CNT_W'(RESUME_TICKS - 1);

    logic             vbus_meta_r, vbus_sync_r;
    logic             dp_meta_r, dp_sync_r;
    logic             dm_meta_r, dm_sync_r;
    logic             line_j_s, line_k_s, line_se0_s;
    logic [2:0]       state_r, state_nxt_s;
    logic             state_chg_s;
    logic [CNT_W-1:0] cnt_r, cnt_nxt_s, cnt_d_s;
    logic [CNT_W-1:0] se0_cnt_r, se0_nxt_s, se0_d_s;
    logic [CNT_W-1:0] j_cnt_r, j_nxt_s, j_d_s;
    logic             pullup_nxt_s, tx_oe_nxt_s, drive_k_nxt_s;
    logic             hs_gnt_nxt_s, data_gnt_nxt_s;
    logic             bus_reset_nxt_s, bus_reset_p_nxt_s, suspend_nxt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (v == {CNT_W{1'b1}}) begin
            sat_inc = v;
        end else begin
            sat_inc = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    endfunction

    // two-flop synchronisers for the asynchronous bus-side inputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            vbus_meta_r <= 1'b0;
            vbus_sync_r <= 1'b0;
            dp_meta_r   <= 1'b0;
            dp_sync_r   <= 1'b0;
            dm_meta_r   <= 1'b0;
            dm_sync_r   <= 1'b0;
        end else begin
            vbus_meta_r <= vbus;
            vbus_sync_r <= vbus_meta_r;
            dp_meta_r   <= line_dp;
            dp_sync_r   <= dp_meta_r;
            dm_meta_r   <= line_dm;
            dm_sync_r   <= dm_meta_r;
        end
    end

    // line decode; SE1 is neither J, K nor SE0 and so falls into the clearing branches
    always_comb begin
        line_se0_s = ~dp_sync_r & ~dm_sync_r;
`ifdef USB_DEV_LINE_CTRL_LS_EN
        line_j_s   = ~dp_sync_r &  dm_sync_r;
        line_k_s   =  dp_sync_r & ~dm_sync_r;
`else
        line_j_s   =  dp_sync_r & ~dm_sync_r;
        line_k_s   = ~dp_sync_r &  dm_sync_r;
`endif
    end

    // state register with the state timer and the two line-run counters
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r   <= ST_DETACH;
            cnt_r     <= CNT_ZERO;
            se0_cnt_r <= CNT_ZERO;
            j_cnt_r   <= CNT_ZERO;
        end else begin
            state_r   <= state_nxt_s;
            cnt_r     <= cnt_d_s;
            se0_cnt_r <= se0_d_s;
            j_cnt_r   <= j_d_s;
        end
    end

    assign state_chg_s = (state_nxt_s != state_r);
    assign cnt_d_s     = state_chg_s ? CNT_ZERO : cnt_nxt_s;
    assign se0_d_s     = state_chg_s ? CNT_ZERO : se0_nxt_s;
    assign j_d_s       = state_chg_s ? CNT_ZERO : j_nxt_s;
    assign state       = state_r;

    // next-state and counter advance
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        se0_nxt_s   = se0_cnt_r;
        j_nxt_s     = j_cnt_r;
        if (!vbus_sync_r) begin
            state_nxt_s = ST_DETACH;
        end else begin
            case (state_r)
                ST_DETACH: begin
                    state_nxt_s = ST_ATTACH_WAIT;
                end
                ST_ATTACH_WAIT: begin
                    if (bit_tick) begin
                        if (cnt_r == CON_LAST) begin
                            state_nxt_s = ST_IDLE;
                        end else begin
                            cnt_nxt_s = sat_inc(cnt_r);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_IDLE: begin
                    // our own transmission must not be mistaken for bus activity
                    if (tx_oe) begin
                        se0_nxt_s = CNT_ZERO;
                        j_nxt_s   = CNT_ZERO;
                    end else if (bit_tick && line_se0_s) begin
                        j_nxt_s = CNT_ZERO;
                        if (se0_cnt_r == RST_LAST) begin
                            state_nxt_s = ST_BUS_RST;
                        end else begin
                            se0_nxt_s = sat_inc(se0_cnt_r);
                        end
                    end else if (bit_tick && line_j_s) begin
                        se0_nxt_s = CNT_ZERO;
                        if (j_cnt_r == SUSP_LAST) begin
                            state_nxt_s = ST_SUSPEND;
                        end else begin
                            j_nxt_s = sat_inc(j_cnt_r);
                        end
                    end else if (bit_tick) begin
                        se0_nxt_s = CNT_ZERO;
                        j_nxt_s   = CNT_ZERO;
                    end else begin
                        se0_nxt_s = se0_cnt_r;
                    end
                end
                ST_BUS_RST: begin
                    if (bit_tick && (line_j_s || line_k_s)) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = state_r;
                    end
                end
                ST_SUSPEND: begin
                    if (bit_tick && line_k_s) begin
                        state_nxt_s = ST_RESUME_WAIT;
                    end else if (bit_tick && line_se0_s && (se0_cnt_r == RST_LAST)) begin
                        state_nxt_s = ST_BUS_RST;
                    end else if (rwk_req) begin
                        state_nxt_s = ST_RESUME_DRV;
                    end else if (bit_tick && line_se0_s) begin
                        se0_nxt_s = sat_inc(se0_cnt_r);
                    end else if (bit_tick) begin
                        se0_nxt_s = CNT_ZERO;
                    end else begin
                        se0_nxt_s = se0_cnt_r;
                    end
                end
                ST_RESUME_DRV: begin
                    if (bit_tick) begin
                        if (cnt_r == RESUME_LAST) begin
                            state_nxt_s = ST_RESUME_WAIT;
                        end else begin
                            cnt_nxt_s = sat_inc(cnt_r);
                        end
                    end else begin
                        cnt_nxt_s = cnt_r;
                    end
                end
                ST_RESUME_WAIT: begin
                    // a non-zero SE0 run means the previous tick was SE0: J now ends the EOP
                    if (bit_tick && line_se0_s) begin
                        if (se0_cnt_r == RST_LAST) begin
                            state_nxt_s = ST_BUS_RST;
                        end else begin
                            se0_nxt_s = sat_inc(se0_cnt_r);
                        end
                    end else if (bit_tick && line_j_s && (se0_cnt_r != CNT_ZERO)) begin
                        state_nxt_s = ST_IDLE;
                    end else if (bit_tick) begin
                        se0_nxt_s = CNT_ZERO;
                    end else begin
                        se0_nxt_s = se0_cnt_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_DETACH;
                end
            endcase
        end
    end

    // output decode from the upcoming state, including transmitter arbitration
    always_comb begin
        hs_gnt_nxt_s   = 1'b0;
        data_gnt_nxt_s = 1'b0;
        if (state_nxt_s != ST_IDLE) begin
            hs_gnt_nxt_s   = 1'b0;
            data_gnt_nxt_s = 1'b0;
        end else if (hs_gnt || data_gnt) begin
            hs_gnt_nxt_s   = hs_gnt & ~tx_done;
            data_gnt_nxt_s = data_gnt & ~tx_done;
        end else if (state_r == ST_IDLE) begin
            hs_gnt_nxt_s   = hs_req;
            data_gnt_nxt_s = data_req & ~hs_req;
        end else begin
            hs_gnt_nxt_s   = 1'b0;
            data_gnt_nxt_s = 1'b0;
        end
        drive_k_nxt_s     = (state_nxt_s == ST_RESUME_DRV);
        tx_oe_nxt_s       = hs_gnt_nxt_s | data_gnt_nxt_s | drive_k_nxt_s;
        pullup_nxt_s      = (state_nxt_s != ST_DETACH) && (state_nxt_s != ST_ATTACH_WAIT);
        bus_reset_nxt_s   = (state_nxt_s == ST_BUS_RST);
        bus_reset_p_nxt_s = (state_nxt_s == ST_BUS_RST) && (state_r != ST_BUS_RST);
        suspend_nxt_s     = (state_nxt_s == ST_SUSPEND);
    end

    // registered outputs
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pullup_en   <= 1'b0;
            tx_oe       <= 1'b0;
            drive_k     <= 1'b0;
            hs_gnt      <= 1'b0;
            data_gnt    <= 1'b0;
            bus_reset   <= 1'b0;
            bus_reset_p <= 1'b0;
            suspend     <= 1'b0;
        end else begin
            pullup_en   <= pullup_nxt_s;
            tx_oe       <= tx_oe_nxt_s;
            drive_k     <= drive_k_nxt_s;
            hs_gnt      <= hs_gnt_nxt_s;
            data_gnt    <= data_gnt_nxt_s;
            bus_reset   <= bus_reset_nxt_s;
            bus_reset_p <= bus_reset_p_nxt_s;
            suspend     <= suspend_nxt_s;
        end
    end

endmodule
